// File: rtl/vector_cache_pkg.sv
// -----------------------------------------------------------------------------
// vector_cache_pkg
//   Types shared across the vector cache SRAM group chain.
//   - txnid_t          : read transaction identifier
//   - arb_out_req_t    : read command payload issued eastward into the chain
//   - group_data_pld_t : read data payload returning after the east-end loop-back
//   - LOOP_RTN_FIFO_DEPTH : default per-lane depth of the loop-return collector
// -----------------------------------------------------------------------------
package vector_cache_pkg;

    localparam int TXNID_W             = 8;
    localparam int DATA_W              = 32;
    localparam int LOOP_RTN_FIFO_DEPTH = 4;

    typedef logic [TXNID_W-1:0] txnid_t;

    typedef struct packed {
        txnid_t txnid;
    } arb_out_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
    } group_data_pld_t;

endpackage

// File: rtl/loop_rtn_lane.sv
// -----------------------------------------------------------------------------
// loop_rtn_lane
//   One lane of the loop-return collector: a tag FIFO holding the IDs of issued
//   read commands, a data FIFO holding looped-back data, a credit counter that
//   keeps un-stallable returns from overflowing the data FIFO, and (optionally)
//   a sticky protocol checker.
//
//   Optional feature: define LOOP_RTN_ERR_CHK_EN to enable the return checker.
//
//   Ports:
//     clk, rst      core clock, asynchronous active-high reset
//     cmd_vld/rdy   read command issue handshake; cmd_txnid is recorded
//     rtn_vld/data  looped-back data, no back-pressure
//     out_vld/rdy   paired entry handshake toward the consumer
//     out_data      data FIFO head
//     out_txnid     tag FIFO head (ID paired with out_data)
//     err           sticky protocol error (0 when the checker is disabled)
// -----------------------------------------------------------------------------
module loop_rtn_lane
    import vector_cache_pkg::*;
#(
    parameter int FIFO_DEPTH = LOOP_RTN_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    input  txnid_t          cmd_txnid,
    output logic            cmd_rdy,
    input  logic            rtn_vld,
    input  group_data_pld_t rtn_data,
    output logic            out_vld,
    output group_data_pld_t out_data,
    output txnid_t          out_txnid,
    input  logic            out_rdy,
    output logic            err
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [IDX_W:0] ptr_t;

    ptr_t             tag_wr, tag_rd, dat_wr, dat_rd;
    txnid_t           tag_mem [FIFO_DEPTH];
    group_data_pld_t  dat_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] credit;
    logic             accept, pop, push;

    assign cmd_rdy   = (credit != '0);
    assign accept    = cmd_vld & cmd_rdy;
    assign out_vld   = (dat_wr != dat_rd);
    assign pop       = out_vld & out_rdy;
    assign out_data  = dat_mem[dat_rd[IDX_W-1:0]];
    assign out_txnid = tag_mem[tag_rd[IDX_W-1:0]];

`ifdef LOOP_RTN_ERR_CHK_EN
    ptr_t tag_occ, dat_occ;
    logic dat_full, bad;

    assign tag_occ  = tag_wr - tag_rd;
    assign dat_occ  = dat_wr - dat_rd;
    assign dat_full = (dat_wr[IDX_W] != dat_rd[IDX_W]) &&
                      (dat_wr[IDX_W-1:0] == dat_rd[IDX_W-1:0]);
    // Data with no outstanding command, or with nowhere to go, is dropped.
    assign bad      = rtn_vld & ((tag_occ <= dat_occ) | dat_full);
    assign push     = rtn_vld & ~bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bad) begin
            err <= 1'b1;
        end
    end
`else
    assign push = rtn_vld;
    assign err  = 1'b0;
`endif

    // NOTE: storage arrays have no reset; only pointers define what is valid,
    // so clearing the contents would add reset fan-out for no benefit.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr[IDX_W-1:0]] <= cmd_txnid;
        end
        if (push) begin
            dat_mem[dat_wr[IDX_W-1:0]] <= rtn_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr <= '0;
            tag_rd <= '0;
            dat_wr <= '0;
            dat_rd <= '0;
            credit <= CNT_W'(FIFO_DEPTH);
        end else begin
            if (accept) tag_wr <= tag_wr + ptr_t'(1);
            if (push)   dat_wr <= dat_wr + ptr_t'(1);
            if (pop) begin
                tag_rd <= tag_rd + ptr_t'(1);
                dat_rd <= dat_rd + ptr_t'(1);
            end
            case ({accept, pop})
                2'b10:   credit <= credit - CNT_W'(1);
                2'b01:   credit <= credit + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/loop_return_collector.sv
// -----------------------------------------------------------------------------
// loop_return_collector
//   West-edge collector for read data returning from the SRAM group chain after
//   the east-end loop-back. Each lane records issued read IDs in order, pairs
//   each looped-back data beat with the oldest recorded ID and presents the pair
//   to a downstream consumer with valid/ready. Lanes are fully independent.
//
//   Optional feature: define LOOP_RTN_ERR_CHK_EN to enable the per-lane sticky
//   return checker driving rtn_err; otherwise rtn_err is tied to 0.
//
//   Ports (all per-lane vectors are [LANE_NUM-1:0]):
//     clk, rst        core clock, asynchronous active-high reset
//     rd_cmd_vld_in   read command issued eastward
//     rd_cmd_pld_in   command payload; txnid is captured
//     rd_cmd_rdy_out  lane has a free credit
//     data_in_vld     looped-back data valid (cannot be stalled)
//     data_in         looped-back data
//     data_out_vld    paired entry available
//     data_out        buffered data
//     data_out_txnid  transaction ID paired with data_out
//     data_out_rdy    consumer accepts the entry
//     rtn_err         sticky per-lane protocol error
// -----------------------------------------------------------------------------
module loop_return_collector
    import vector_cache_pkg::*;
#(
    parameter int LANE_NUM   = 8,
    parameter int FIFO_DEPTH = LOOP_RTN_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic            [LANE_NUM-1:0]   rd_cmd_vld_in,
    input  arb_out_req_t    [LANE_NUM-1:0]   rd_cmd_pld_in,
    output logic            [LANE_NUM-1:0]   rd_cmd_rdy_out,
    input  logic            [LANE_NUM-1:0]   data_in_vld,
    input  group_data_pld_t [LANE_NUM-1:0]   data_in,
    output logic            [LANE_NUM-1:0]   data_out_vld,
    output group_data_pld_t [LANE_NUM-1:0]   data_out,
    output txnid_t          [LANE_NUM-1:0]   data_out_txnid,
    input  logic            [LANE_NUM-1:0]   data_out_rdy,
    output logic            [LANE_NUM-1:0]   rtn_err
);

    for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
        loop_rtn_lane #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .cmd_vld   (rd_cmd_vld_in[i]),
            .cmd_txnid (rd_cmd_pld_in[i].txnid),
            .cmd_rdy   (rd_cmd_rdy_out[i]),
            .rtn_vld   (data_in_vld[i]),
            .rtn_data  (data_in[i]),
            .out_vld   (data_out_vld[i]),
            .out_data  (data_out[i]),
            .out_txnid (data_out_txnid[i]),
            .out_rdy   (data_out_rdy[i]),
            .err       (rtn_err[i])
        );
    end

endmodule

// File: tb/tb_loop_return_collector.sv
// -----------------------------------------------------------------------------
// tb_loop_return_collector
//   Self-checking bench for loop_return_collector (8 lanes, depth 4).
// -----------------------------------------------------------------------------
module tb_loop_return_collector;
    import vector_cache_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic            [7:0] cmd_vld;
    arb_out_req_t    [7:0] cmd_pld;
    logic            [7:0] cmd_rdy;
    logic            [7:0] din_vld;
    group_data_pld_t [7:0] din;
    logic            [7:0] dout_vld;
    group_data_pld_t [7:0] dout;
    txnid_t          [7:0] dout_txnid;
    logic            [7:0] dout_rdy;
    logic            [7:0] rtn_err;

    int n_checks = 0;
    int n_pass   = 0;

    loop_return_collector #(
        .LANE_NUM   (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_cmd_vld_in  (cmd_vld),
        .rd_cmd_pld_in  (cmd_pld),
        .rd_cmd_rdy_out (cmd_rdy),
        .data_in_vld    (din_vld),
        .data_in        (din),
        .data_out_vld   (dout_vld),
        .data_out       (dout),
        .data_out_txnid (dout_txnid),
        .data_out_rdy   (dout_rdy),
        .rtn_err        (rtn_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_vld  = '0;
        cmd_pld  = '0;
        din_vld  = '0;
        din      = '0;
        dout_rdy = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        #1;
        check("reset_rdy", cmd_rdy, 8'hFF);
        check("reset_vld", dout_vld, 8'h00);
        check("reset_err", rtn_err, 8'h00);
        tick();
        rst = 1'b0;
    endtask

    // Lane-0 directed vectors: inputs for one cycle, expected outputs after the edge.
    typedef struct packed {
        logic        cmd;
        logic [7:0]  txn;
        logic        din_v;
        logic [31:0] din;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_txn;
        logic [31:0] e_dat;
    } vec_t;

    function automatic vec_t mk(logic c, logic [7:0] t, logic dv, logic [31:0] d,
                                logic r, logic er, logic ev, logic [7:0] et, logic [31:0] ed);
        vec_t v;
        v.cmd = c; v.txn = t; v.din_v = dv; v.din = d; v.ordy = r;
        v.e_rdy = er; v.e_vld = ev; v.e_txn = et; v.e_dat = ed;
        return v;
    endfunction

    vec_t tbl [15];

    // Reference model: per-lane lists of accepted-but-unpopped IDs and of
    // returned-but-unpopped data. Credits are DEPTH minus unpopped commands.
    logic [7:0]  tq [8][$];
    logic [31:0] dq [8][$];
    int          seq [8];

    initial begin
        //           cmd txn    dv din       ordy  rdy vld txn    data
        tbl[0]  = mk(1, 8'h05, 0, 32'h0,     0,    1,  0,  8'h00, 32'h0);
        tbl[1]  = mk(0, 8'h00, 0, 32'h0,     0,    1,  0,  8'h00, 32'h0);
        tbl[2]  = mk(0, 8'h00, 1, 32'hA5A5,  0,    1,  1,  8'h05, 32'hA5A5);
        tbl[3]  = mk(0, 8'h00, 0, 32'h0,     0,    1,  1,  8'h05, 32'hA5A5);
        tbl[4]  = mk(0, 8'h00, 0, 32'h0,     1,    1,  0,  8'h00, 32'h0);
        tbl[5]  = mk(1, 8'h10, 0, 32'h0,     0,    1,  0,  8'h00, 32'h0);
        tbl[6]  = mk(1, 8'h11, 0, 32'h0,     0,    1,  0,  8'h00, 32'h0);
        tbl[7]  = mk(1, 8'h12, 0, 32'h0,     0,    1,  0,  8'h00, 32'h0);
        tbl[8]  = mk(1, 8'h13, 0, 32'h0,     0,    0,  0,  8'h00, 32'h0);
        tbl[9]  = mk(1, 8'h14, 0, 32'h0,     0,    0,  0,  8'h00, 32'h0);
        tbl[10] = mk(0, 8'h00, 1, 32'h100,   0,    0,  1,  8'h10, 32'h100);
        tbl[11] = mk(0, 8'h00, 0, 32'h0,     1,    1,  0,  8'h00, 32'h0);
        tbl[12] = mk(0, 8'h00, 1, 32'h101,   0,    1,  1,  8'h11, 32'h101);
        tbl[13] = mk(1, 8'h14, 0, 32'h0,     1,    1,  0,  8'h00, 32'h0);
        tbl[14] = mk(0, 8'h00, 1, 32'h102,   1,    1,  1,  8'h12, 32'h102);

        do_reset();

        // Directed single-lane sequence: latency, credit exhaustion, dropped
        // command at rdy=0, credit return latency, same-cycle accept+pop.
        for (int i = 0; i < 15; i++) begin
            idle();
            cmd_vld[0]       = tbl[i].cmd;
            cmd_pld[0].txnid = tbl[i].txn;
            din_vld[0]       = tbl[i].din_v;
            din[0].data      = tbl[i].din;
            dout_rdy[0]      = tbl[i].ordy;
            tick();
            check($sformatf("vec%0d_rdy", i), cmd_rdy, {7'h7F, tbl[i].e_rdy});
            check($sformatf("vec%0d_vld", i), dout_vld, {7'h00, tbl[i].e_vld});
            if (tbl[i].e_vld)
                check($sformatf("vec%0d_out", i), {dout_txnid[0], dout[0].data},
                      {tbl[i].e_txn, tbl[i].e_dat});
        end

        // Mid-operation reset with commands and data still in flight.
        do_reset();

        // Back-pressure on lane 3, two rounds of four to wrap pointers twice.
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 0; k < 4; k++) begin
                idle();
                cmd_vld[3]       = 1'b1;
                cmd_pld[3].txnid = 8'(8'h30 + rnd * 4 + k);
                tick();
            end
            check("bp_rdy_low", cmd_rdy[3], 1'b0);
            for (int k = 0; k < 4; k++) begin
                idle();
                din_vld[3]  = 1'b1;
                din[3].data = 32'(32'h3000 + rnd * 4 + k);
                tick();
            end
            idle();
            for (int c = 0; c < 10; c++) begin
                tick();
                check("bp_hold_vld", dout_vld[3], 1'b1);
                check("bp_hold_out", {dout_txnid[3], dout[3].data},
                      {8'(8'h30 + rnd * 4), 32'(32'h3000 + rnd * 4)});
            end
            for (int k = 0; k < 4; k++) begin
                idle();
                dout_rdy[3] = 1'b1;
                check("bp_drain_out", {dout_txnid[3], dout[3].data},
                      {8'(8'h30 + rnd * 4 + k), 32'(32'h3000 + rnd * 4 + k)});
                tick();
            end
            check("bp_empty", dout_vld[3], 1'b0);
            check("bp_rdy_back", cmd_rdy[3], 1'b1);
        end

        // Return checker: data on lane 2 with no command outstanding.
        do_reset();
        idle();
        din_vld[2]  = 1'b1;
        din[2].data = 32'hDEAD;
        tick();
        idle();
`ifdef LOOP_RTN_ERR_CHK_EN
        check("err_set", rtn_err, 8'h04);
        check("err_dropped", dout_vld[2], 1'b0);
        cmd_vld[2]       = 1'b1;
        cmd_pld[2].txnid = 8'h22;
        tick();
        idle();
        din_vld[2]  = 1'b1;
        din[2].data = 32'h2222;
        tick();
        idle();
        tick();
        check("err_sticky", rtn_err, 8'h04);
        check("err_legal_out", {dout_txnid[2], dout[2].data}, {8'h22, 32'h2222});
`else
        check("err_off", rtn_err, 8'h00);
        check("push_uncond", dout_vld[2], 1'b1);
`endif
        do_reset();

        // Randomized all-lane traffic against the queue model.
        for (int l = 0; l < 8; l++) seq[l] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [7:0] e_rdy;
            logic [7:0] e_vld;
            for (int l = 0; l < 8; l++) begin
                e_rdy[l] = (tq[l].size() < 4);
                e_vld[l] = (dq[l].size() > 0);
            end
            check("rand_rdy", cmd_rdy, e_rdy);
            check("rand_vld", dout_vld, e_vld);
            for (int l = 0; l < 8; l++)
                if (e_vld[l])
                    check($sformatf("rand_out_l%0d", l), {dout_txnid[l], dout[l].data},
                          {tq[l][0], dq[l][0]});
            idle();
            for (int l = 0; l < 8; l++) begin
                cmd_vld[l]       = 1'($urandom_range(0, 1));
                cmd_pld[l].txnid = {3'(l), 5'(seq[l])};
                din_vld[l]       = (tq[l].size() > dq[l].size()) && ($urandom_range(0, 3) != 0);
                din[l].data      = $urandom;
                dout_rdy[l]      = 1'($urandom_range(0, 1));
                if (dout_rdy[l] && e_vld[l]) begin
                    void'(tq[l].pop_front());
                    void'(dq[l].pop_front());
                end
                if (din_vld[l]) dq[l].push_back(din[l].data);
                if (cmd_vld[l] && e_rdy[l]) begin
                    tq[l].push_back(cmd_pld[l].txnid);
                    seq[l]++;
                end
            end
            tick();
        end
        check("rand_no_err", rtn_err, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/loop_return_collector.md
# loop_return_collector

West-edge collector for read data returning from the SRAM group chain after east-end loop-back. For each of 8 lanes, it records read commands as they are issued eastward into the chain and holds their transaction IDs in order. When looped-back data arrives on the lane, it pairs the data with the oldest recorded ID and buffers both for a downstream consumer using valid/ready. Per-lane credits guarantee that returning data, which has no back-pressure, always finds buffer space.

## Interface
Parameters:
- LANE_NUM, 8, number of lanes; ports below are `[LANE_NUM-1:0]`.
- FIFO_DEPTH, 4, entries per lane; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the credit and occupancy counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- rd_cmd_vld_in  in  8  read command issued eastward, one per lane.
- rd_cmd_pld_in  in  arb_out_req_t[8]  command payload; `txnid` is captured.
- rd_cmd_rdy_out  out  8  lane has a free credit.
- data_in_vld  in  8  looped-back read data valid; cannot be stalled.
- data_in  in  group_data_pld_t[8]  looped-back data.
- data_out_vld  out  8  paired entry available.
- data_out  out  group_data_pld_t[8]  buffered data.
- data_out_txnid  out  txnid_t[8]  transaction ID paired with `data_out`.
- data_out_rdy  in  8  consumer accepts the entry.
- rtn_err  out  8  sticky per-lane protocol error (see Configuration).

## Operation
- A command is accepted when `rd_cmd_vld_in[i] & rd_cmd_rdy_out[i]`. Acceptance pushes `rd_cmd_pld_in[i].txnid` into the lane's tag FIFO and decrements the lane's credit.
- Data is written when `data_in_vld[i]`. It pushes into the lane's data FIFO. Returns on a lane come back in issue order, so no tag matching is needed.
- `data_out_vld[i]` = lane data FIFO not empty. `data_out` is the data FIFO head; `data_out_txnid` is the tag FIFO head.
- A pop occurs on `data_out_vld[i] & data_out_rdy[i]`. It pops both FIFOs and returns one credit.
- Credit counter:
  - reset value FIFO_DEPTH;
  - −1 on accept, +1 on pop;
  - accept and pop in the same cycle: unchanged;
  - `rd_cmd_rdy_out[i]` = (credit ≠ 0).
- A `rd_cmd_vld_in` that arrives with `rdy`=0 is dropped. The issuer must hold it.
- Lanes are fully independent; there is no inter-lane ordering.
- FIFO pointers have one extra wrap bit. Full: low bits equal and wrap bits differ. Empty: pointers equal. The wrap from index FIFO_DEPTH-1 to 0 is exercised.
- Push and pop on the same cycle to a full or an empty data FIFO are both legal:
  - Full: a legal push to a full FIFO cannot occur because of credits.
  - Empty: the same-cycle push is not visible until the next cycle.

## Timing
- Reset values: `rd_cmd_rdy_out`=8'hFF, `data_out_vld`=0, `rtn_err`=0. `data_out` and `data_out_txnid` are don't-care while `vld`=0. All pointers and counters reset to 0; credits reset to FIFO_DEPTH.
- Data latency: `data_in_vld` at cycle N → `data_out_vld` at N+1. There is no combinational path from in to out.
- Credit latency: pop at N → `rd_cmd_rdy_out` rises at N+1 if it was 0.
- Accept at N lowers credit at N+1.
- `data_out_vld`, `data_out` and `data_out_txnid` stay stable while `vld=1` and `rdy=0`.
- Reset asserted mid-operation flushes all FIFOs and restores all credits at once, regardless of data in flight. Upstream must also be reset.

## Configuration
- `LOOP_RTN_ERR_CHK_EN` defined:
  - `rtn_err[i]` sets if `data_in_vld[i]` arrives when the tag FIFO occupancy is ≤ the data FIFO occupancy, meaning data arrived with no outstanding command.
  - It also sets on a data push to a full data FIFO.
  - It clears only on `rst`.
  - The offending push is discarded.
- Not defined: `rtn_err` is tied to 0, the checker logic is absent, and pushes are unconditional.

## Structure
- Shared package `vector_cache_pkg` supplies `arb_out_req_t`, `group_data_pld_t` and `txnid_t`. Add `LOOP_RTN_FIFO_DEPTH` to the package as the default depth.
- Sub-module `loop_rtn_lane`: one lane's tag FIFO, data FIFO, credit counter and error checker. The top level instantiates it LANE_NUM times in a generate loop.

## Test plan
- Single lane 0: issue txnid 5, return data 32'hA5A5 two cycles later → `data_out_vld[0]` the next cycle with data A5A5 and txnid 5; credit back at 4 after the pop.
- Issue 4 commands on lane 3 with no pops → `rd_cmd_rdy_out[3]`=0. The fifth command is held, not accepted. Pop one → `rdy` returns to 1 one cycle later.
- Same-cycle accept and pop on lane 1 at credit 1 → credit stays 1 and `rdy` stays 1.
- Back-pressure: 4 returns with `data_out_rdy`=0 for 10 cycles → the outputs hold. Release → txnids drain in issue order, exercising the pointer wrap twice over 8 transactions.
- All 8 lanes concurrent, with distinct txnids and random `rdy` → each lane's output order matches its issue order, with no cross-lane mixing.
- `LOOP_RTN_ERR_CHK_EN`: `data_in_vld[2]` with no command outstanding → `rtn_err[2]`=1 the next cycle, `data_out_vld[2]` stays 0, and the error stays sticky until `rst`.
